elastic_pipereg: RTL and testbench
==================================

ELASTIC_PIPEREG -- requirements
Module: elastic_pipereg

Interface
REQ-001 Parameter WIDTH, default 32, payload bits per entry (1..256).
REQ-002 Parameter DEPTH, default 2, entry count; power of two, 2..16.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers an entry.
REQ-006 in_ready  output  1  buffer accepts; enqueue when in_valid & in_ready.
REQ-007 in_data  input  WIDTH  payload.
REQ-008 in_keep  input  1  entry survives flush (NOT_FLUSH semantics).
REQ-009 out_valid  output  1  head entry live and presented.
REQ-010 out_ready  input  1  consumer takes head; dequeue when out_valid & out_ready.
REQ-011 out_data  output  WIDTH  head payload; all-zero whenever out_valid=0.
REQ-012 out_keep  output  1  keep bit of head; 0 whenever out_valid=0.
REQ-013 stall  input  1  freezes buffer.
REQ-014 flush  input  1  kills all non-keep entries.
REQ-015 count  output  $clog2(DEPTH)+1  occupied slots, bubbles included.

Function
REQ-016 Storage is a circular buffer of DEPTH slots {live, keep, data}; read/write pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
REQ-017 in_ready = !full & !stall; depends only on registered state and stall, never on out_ready.
REQ-018 out_valid = head slot occupied & live & !stall.
REQ-019 Without bypass (REQ-030), latency in_valid&in_ready -> out_valid is exactly 1 cycle; throughput 1 entry/cycle when out_ready held high.
REQ-020 Full (count=DEPTH) with simultaneous dequeue: no enqueue that cycle; in_ready rises the next cycle.
REQ-021 Empty: out_valid=0, count=0; dequeue impossible.
REQ-022 Simultaneous enqueue and dequeue when neither full nor empty: count unchanged, both pointers advance.
REQ-023 Bubble: occupied head slot with live=0 is discarded automatically, one per cycle, without handshake, unless stall=1.
REQ-024 stall=1: no enqueue, no dequeue, no bubble discard; storage, pointers, count hold.
REQ-025 flush=1: every occupied slot with keep=0 has live cleared on that edge; keep=1 slots unchanged; pointers and count unchanged.
REQ-026 flush has priority over stall: applied even when stall=1.
REQ-027 flush coincident with enqueue: new entry stored with live=in_keep.
REQ-028 flush coincident with dequeue: dequeued head leaves normally; not rewritten.

Reset
REQ-029 reset=1 on an edge: pointers 0, all live/keep/data cleared to 0, count=0; after reset out_valid=0, out_data=0, out_keep=0, in_ready=1 (stall=0); reset overrides flush, stall and any in-flight handshake, mid-operation contents discarded.

Configuration
REQ-030 Macro ELASTIC_PIPEREG_BYPASS_EN: defined -> when count=0, in_valid=1, stall=0, flush=0, out_valid/out_data/out_keep drive in_data combinationally same cycle; if out_ready=1 entry consumed without being stored (count stays 0), else stored normally; undefined -> no combinational in->out path, REQ-019 latency applies.

Verification
REQ-031 WIDTH=32 DEPTH=4, out_ready=1, enqueue 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 1,2,3 (no bypass); count peaks at 1.
REQ-032 out_ready=0, enqueue 5 entries -> in_ready=0 after 4th, count=4; raise out_ready with in_valid=1 -> 5th accepted one cycle after first dequeue, order preserved across pointer wrap.
REQ-033 Load A(keep=0), B(keep=1), C(keep=0), pulse flush with stall=1 -> after stall drops, only B emerges, 2 bubble-discard cycles, count 3->0.
REQ-034 stall=1 for 3 cycles with buffer holding 0xAA and in_valid=1 -> in_ready=0, out_valid=0, count constant; stall drop -> 0xAA delivered next cycle.
REQ-035 reset asserted with count=3 and flush=1 -> next cycle count=0, out_valid=0, out_data=0, in_ready=1.
REQ-036 With ELASTIC_PIPEREG_BYPASS_EN, empty, in_valid=1 data 0x5A, out_ready=1 -> out_valid=1 out_data=0x5A same cycle, count stays 0.

Source files
------------

// File: rtl/elastic_pipereg.sv
// elastic_pipereg: circular-buffer pipeline register with stall, keep-aware flush and bubble squashing.
// Optional same-cycle in->out bypass when empty is enabled by defining ELASTIC_PIPEREG_BYPASS_EN.
module elastic_pipereg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_keep,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_keep,
    input  logic                     stall,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]            live_q, live_d;
    logic [DEPTH-1:0]            keep_q, keep_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic full, empty, head_live, stored_vld, byp, push, pop;

    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        empty      = (count_q == '0);
        head_live  = live_q[rd_ptr_q];
        stored_vld = !empty && head_live && !stall;
`ifdef ELASTIC_PIPEREG_BYPASS_EN
        byp        = empty && in_valid && !stall && !flush;
`else
        byp        = 1'b0;
`endif
        in_ready   = !full && !stall;
        out_valid  = stored_vld || byp;
        out_data   = '0;
        out_keep   = 1'b0;
        if (byp) begin
            out_data = in_data;
            out_keep = in_keep;
        end else if (stored_vld) begin
            out_data = data_q[rd_ptr_q];
            out_keep = keep_q[rd_ptr_q];
        end
        // A bypassed entry that is taken immediately never touches storage.
        push = in_valid && in_ready && !(byp && out_ready);
        // Dead heads drain on their own; live heads need the consumer.
        pop  = !empty && !stall && (!head_live || out_ready);
    end

    assign count = count_q;

    always_comb begin
        live_d   = live_q;
        keep_d   = keep_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) && !keep_q[i])
                    live_d[i] = 1'b0;
            end
        end
        if (push) begin
            live_d[wr_ptr_q] = flush ? in_keep : 1'b1;
            keep_d[wr_ptr_q] = in_keep;
            data_d[wr_ptr_q] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q   <= '0;
            keep_q   <= '0;
            data_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            keep_q   <= keep_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_elastic_pipereg.sv
// Randomized + directed bench for elastic_pipereg against a queue-of-entries reference model.
module tb_elastic_pipereg;
    localparam int W = 32;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, in_keep, out_valid, out_ready, out_keep, stall, flush;
    logic [W-1:0]  in_data, out_data;
    logic [2:0]    count;

    elastic_pipereg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .stall(stall), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic live; logic keep; logic [W-1:0] data; } ent_t;
    ent_t mq[$];

    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;
    logic mon_ready = 1'b0;
    logic mon_byp_take = 1'b0;
    logic last_acc = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares presented outputs with the model head, then retires delivered/dead heads.
    always begin
        logic          e_valid, e_ready, e_keep;
        logic [W-1:0]  e_data;
        int            sz;
        @(negedge clk);
        sz = mq.size();
        e_ready = (sz < D) && !stall;
        e_valid = (sz > 0) && mq[0].live && !stall;
        e_data  = e_valid ? mq[0].data : '0;
        e_keep  = e_valid ? mq[0].keep : 1'b0;
        mon_byp_take = 1'b0;
`ifdef ELASTIC_PIPEREG_BYPASS_EN
        if (sz == 0 && in_valid && !stall && !flush) begin
            e_valid = 1'b1;
            e_data  = in_data;
            e_keep  = in_keep;
            mon_byp_take = out_ready;
        end
`endif
        mon_ready = e_ready;
        if (chk_en) begin
            chk("out_valid", W'(out_valid), W'(e_valid));
            chk("out_data",  out_data, e_data);
            chk("out_keep",  W'(out_keep), W'(e_keep));
            chk("count",     W'(count), W'(sz));
            chk("in_ready",  W'(in_ready), W'(e_ready));
        end
        if (!reset) begin
            if (sz > 0 && !stall && (!mq[0].live || out_ready))
                void'(mq.pop_front());
            if (flush)
                foreach (mq[i]) if (!mq[i].keep) mq[i].live = 1'b0;
        end
    end

    // One cycle of stimulus; the accepted entry is pushed to the scoreboard after the monitor ran.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic k, input logic ordy,
                       input logic st, input logic fl, input logic rs);
        ent_t e;
        in_valid = v; in_data = d; in_keep = k; out_ready = ordy;
        stall = st; flush = fl; reset = rs;
        @(negedge clk);
        #1;
        last_acc = 1'b0;
        if (rs) begin
            mq.delete();
        end else if (v && mon_ready) begin
            last_acc = 1'b1;
            if (!mon_byp_take) begin
                e.live = fl ? k : 1'b1;
                e.keep = k;
                e.data = d;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, ordy, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_keep = 0; out_ready = 0; stall = 0; flush = 0; reset = 1;
        cyc(0, '0, 0, 0, 0, 0, 1);
        cyc(0, '0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        idle(2, 1'b1);

        // Back-to-back streaming with out_ready high.
        cyc(1, 32'h11, 0, 1, 0, 0, 0);
        cyc(1, 32'h22, 0, 1, 0, 0, 0);
        cyc(1, 32'h33, 0, 1, 0, 0, 0);
        idle(3, 1'b1);

        // Fill to full, then drain while the 5th entry waits for space (pointer wrap).
        for (int i = 1; i <= 5; i++) cyc(1, W'(i), 0, 0, 0, 0, 0);
        begin
            logic got5 = 1'b0;
            for (int t = 0; t < 10 && !got5; t++) begin
                cyc(1, 32'h5, 0, 1, 0, 0, 0);
                got5 = last_acc;
            end
            if (!got5) begin
                errors++; checks++;
                $display("FAIL fifth_accept: got not-accepted expected accepted within 10 cycles");
            end
        end
        idle(6, 1'b1);

        // Keep-aware flush under stall, then drain through bubbles.
        cyc(1, 32'hA, 0, 0, 0, 0, 0);
        cyc(1, 32'hB, 1, 0, 0, 0, 0);
        cyc(1, 32'hC, 0, 0, 0, 0, 0);
        cyc(0, '0, 0, 0, 1, 1, 0);
        cyc(0, '0, 0, 0, 1, 0, 0);
        idle(5, 1'b1);

        // Stall holding a stored entry while the producer keeps offering.
        cyc(1, 32'hAA, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'hBB, 0, 1, 1, 0, 0);
        idle(3, 1'b1);

        // Reset with three entries held and flush asserted.
        for (int i = 0; i < 3; i++) cyc(1, W'(32'h70 + i), 0, 0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0, 1, 1);
        idle(2, 1'b1);

        // Flush coincident with enqueue and dequeue.
        cyc(1, 32'h81, 0, 0, 0, 0, 0);
        cyc(1, 32'h82, 1, 1, 0, 1, 0);
        cyc(1, 32'h83, 0, 1, 0, 1, 0);
        idle(4, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 249) == 0));
        end
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
